// File: rtl/alu_result_checker.sv
// In-system scoreboard for the alu interface: predicts each issued result, aligns it
// to the ALU output through a LATENCY-deep delay line, and tallies pass/fail.
module alu_result_checker #(
   parameter int unsigned W_DATA_IN  = 8,
   parameter int unsigned W_DATA_OP  = 2,
   parameter int unsigned W_DATA_OUT = 8,
   parameter int unsigned LATENCY    = 1,
   parameter int unsigned W_CNT      = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_stop,
   input  logic                  i_valid,
   input  logic [W_DATA_IN-1:0]  i_a,
   input  logic [W_DATA_IN-1:0]  i_b,
   input  logic [W_DATA_OP-1:0]  i_op,
   input  logic [W_DATA_OUT-1:0] i_result,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [W_CNT-1:0]      o_pass_cnt,
   output logic [W_CNT-1:0]      o_fail_cnt,
   output logic                  o_err,
   output logic [W_DATA_IN-1:0]  o_err_a,
   output logic [W_DATA_IN-1:0]  o_err_b,
   output logic [W_DATA_OP-1:0]  o_err_op,
   output logic [W_DATA_OUT-1:0] o_err_exp,
   output logic [W_DATA_OUT-1:0] o_err_got
);

   localparam int unsigned W_EXT = (W_DATA_IN > W_DATA_OUT) ? W_DATA_IN : W_DATA_OUT;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef struct packed {
      logic [W_DATA_IN-1:0]  a;
      logic [W_DATA_IN-1:0]  b;
      logic [W_DATA_OP-1:0]  op;
      logic [W_DATA_OUT-1:0] res;
   } payload_t;

   logic [1:0]                state_q, state_d;
   logic [LATENCY-1:0]        vld_q, vld_d;
   logic [LATENCY:0]          vld_sh;
   payload_t [LATENCY-1:0]    pl_q, pl_d;
   payload_t [LATENCY:0]      pl_sh;
   payload_t                  pl_new, tail;
   logic [W_CNT-1:0]          pass_q, pass_d, fail_q, fail_d;
   logic                      err_q, err_d;
   logic [W_DATA_IN-1:0]      err_a_q, err_a_d, err_b_q, err_b_d;
   logic [W_DATA_OP-1:0]      err_op_q, err_op_d;
   logic [W_DATA_OUT-1:0]     err_exp_q, err_exp_d, err_got_q, err_got_d;
   logic [W_EXT-1:0]          ea, eb, er;

   always_comb begin : predict
      ea = W_EXT'(i_a);
      eb = W_EXT'(i_b);
      if (i_op == W_DATA_OP'(0))      er = ea + eb;
      else if (i_op == W_DATA_OP'(1)) er = ea - eb;
      else if (i_op == W_DATA_OP'(2)) er = ea & eb;
      else                            er = ea | eb;
      pl_new.a   = i_a;
      pl_new.b   = i_b;
      pl_new.op  = i_op;
      pl_new.res = er[W_DATA_OUT-1:0];
   end

   // Valid bits and payload shift as one extra-wide vector so LATENCY=1 needs no special case.
   always_comb begin : next_state
      vld_sh    = {vld_q, (state_q == S_RUN) && i_valid && !i_start};
      pl_sh     = {pl_q, pl_new};
      vld_d     = i_start ? '0 : vld_sh[LATENCY-1:0];
      pl_d      = pl_sh[LATENCY-1:0];
      tail      = pl_q[LATENCY-1];
      state_d   = state_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      err_d     = err_q;
      err_a_d   = err_a_q;
      err_b_d   = err_b_q;
      err_op_d  = err_op_q;
      err_exp_d = err_exp_q;
      err_got_d = err_got_q;
      if (i_start) begin
         state_d   = S_RUN;
         pass_d    = '0;
         fail_d    = '0;
         err_d     = 1'b0;
         err_a_d   = '0;
         err_b_d   = '0;
         err_op_d  = '0;
         err_exp_d = '0;
         err_got_d = '0;
      end else begin
         if (vld_q[LATENCY-1]) begin
            if (i_result == tail.res) begin
               if (pass_q != '1) pass_d = pass_q + W_CNT'(1);
            end else begin
               if (fail_q != '1) fail_d = fail_q + W_CNT'(1);
               if (!err_q) begin
                  err_d     = 1'b1;
                  err_a_d   = tail.a;
                  err_b_d   = tail.b;
                  err_op_d  = tail.op;
                  err_exp_d = tail.res;
                  err_got_d = i_result;
               end
            end
         end
         case (state_q)
            S_RUN:   if (i_stop) state_d = S_DRAIN;
            S_DRAIN: if (vld_d == '0) state_d = S_DONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         vld_q     <= '0;
         pl_q      <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         err_q     <= 1'b0;
         err_a_q   <= '0;
         err_b_q   <= '0;
         err_op_q  <= '0;
         err_exp_q <= '0;
         err_got_q <= '0;
      end else begin
         state_q   <= state_d;
         vld_q     <= vld_d;
         pl_q      <= pl_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         err_q     <= err_d;
         err_a_q   <= err_a_d;
         err_b_q   <= err_b_d;
         err_op_q  <= err_op_d;
         err_exp_q <= err_exp_d;
         err_got_q <= err_got_d;
      end
   end

   assign o_busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign o_done     = (state_q == S_DONE);
   assign o_pass_cnt = pass_q;
   assign o_fail_cnt = fail_q;
   assign o_err      = err_q;
   assign o_err_a    = err_a_q;
   assign o_err_b    = err_b_q;
   assign o_err_op   = err_op_q;
   assign o_err_exp  = err_exp_q;
   assign o_err_got  = err_got_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: three instances (LATENCY 1, LATENCY 3, 2-bit counters)
// share one operation stream and are each compared against a cycle-level scoreboard model.
module tb_alu_result_checker;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic       clk = 1'b0;
   logic       rst, start, stop, valid;
   logic [7:0] a, b;
   logic [1:0] op;
   logic [7:0] r0, r1, r2;

   logic        d0_busy, d0_done, d0_err, d1_busy, d1_done, d1_err, d2_busy, d2_done, d2_err;
   logic [15:0] d0_pass, d0_fail, d1_pass, d1_fail;
   logic [1:0]  d2_pass, d2_fail;
   logic [7:0]  d0_ea, d0_eb, d0_ee, d0_eg, d1_ea, d1_eb, d1_ee, d1_eg, d2_ea, d2_eb, d2_ee, d2_eg;
   logic [1:0]  d0_eo, d1_eo, d2_eo;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;

   int unsigned lat[3]  = '{1, 3, 1};
   int unsigned cmax[3] = '{65535, 65535, 3};
   int          ph[3];
   bit          pend[3][8];
   int unsigned mp[3], mf[3], mea[3], meb[3], meo[3], mee[3], meg[3];
   bit          me[3];
   int unsigned ha[8], hb[8], hop[8], hfv[8];
   bit          hv[8], hf[8];

   always #5 clk = ~clk;

   alu_result_checker #(.LATENCY(1)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_valid(valid),
      .i_a(a), .i_b(b), .i_op(op), .i_result(r0),
      .o_busy(d0_busy), .o_done(d0_done), .o_pass_cnt(d0_pass), .o_fail_cnt(d0_fail),
      .o_err(d0_err), .o_err_a(d0_ea), .o_err_b(d0_eb), .o_err_op(d0_eo),
      .o_err_exp(d0_ee), .o_err_got(d0_eg));

   alu_result_checker #(.LATENCY(3)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_valid(valid),
      .i_a(a), .i_b(b), .i_op(op), .i_result(r1),
      .o_busy(d1_busy), .o_done(d1_done), .o_pass_cnt(d1_pass), .o_fail_cnt(d1_fail),
      .o_err(d1_err), .o_err_a(d1_ea), .o_err_b(d1_eb), .o_err_op(d1_eo),
      .o_err_exp(d1_ee), .o_err_got(d1_eg));

   alu_result_checker #(.LATENCY(1), .W_CNT(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_valid(valid),
      .i_a(a), .i_b(b), .i_op(op), .i_result(r2),
      .o_busy(d2_busy), .o_done(d2_done), .o_pass_cnt(d2_pass), .o_fail_cnt(d2_fail),
      .o_err(d2_err), .o_err_a(d2_ea), .o_err_b(d2_eb), .o_err_op(d2_eo),
      .o_err_exp(d2_ee), .o_err_got(d2_eg));

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int unsigned alu_ref(input int unsigned x, input int unsigned y,
                                           input int unsigned o);
      case (o)
         0:       return (x + y) & 255;
         1:       return (x - y) & 255;
         2:       return x & y;
         default: return x | y;
      endcase
   endfunction

   task automatic model_clear(input int d);
      for (int s = 0; s < 8; s++) pend[d][s] = 1'b0;
      mp[d] = 0; mf[d] = 0; me[d] = 1'b0;
      mea[d] = 0; meb[d] = 0; meo[d] = 0; mee[d] = 0; meg[d] = 0;
   endtask

   task automatic model_edge(input int d, input bit v, input bit st, input bit sp,
                             input bit r, input int unsigned got);
      int unsigned k, e;
      bit any;
      if (r) begin
         model_clear(d);
         ph[d] = P_IDLE;
      end else if (st) begin
         model_clear(d);
         ph[d] = P_RUN;
      end else begin
         k = (cyc + 8 - lat[d]) % 8;
         if (pend[d][k]) begin
            pend[d][k] = 1'b0;
            e = alu_ref(ha[k], hb[k], hop[k]);
            if (got == e) begin
               if (mp[d] < cmax[d]) mp[d]++;
            end else begin
               if (mf[d] < cmax[d]) mf[d]++;
               if (!me[d]) begin
                  me[d] = 1'b1; mea[d] = ha[k]; meb[d] = hb[k]; meo[d] = hop[k];
                  mee[d] = e; meg[d] = got;
               end
            end
         end
         pend[d][cyc % 8] = 1'b0;
         if (ph[d] == P_RUN) begin
            pend[d][cyc % 8] = v;
            if (sp) ph[d] = P_DRAIN;
         end else if (ph[d] == P_DRAIN) begin
            any = 1'b0;
            for (int s = 0; s < 8; s++) any |= pend[d][s];
            if (!any) ph[d] = P_DONE;
         end
      end
   endtask

   task automatic check_dut(input int d);
      logic bz, dn, er;
      int unsigned p, f, xa, xb, xo, xe, xg;
      case (d)
         0: begin bz = d0_busy; dn = d0_done; er = d0_err; p = d0_pass; f = d0_fail;
                  xa = d0_ea; xb = d0_eb; xo = d0_eo; xe = d0_ee; xg = d0_eg; end
         1: begin bz = d1_busy; dn = d1_done; er = d1_err; p = d1_pass; f = d1_fail;
                  xa = d1_ea; xb = d1_eb; xo = d1_eo; xe = d1_ee; xg = d1_eg; end
         default: begin bz = d2_busy; dn = d2_done; er = d2_err; p = 32'(d2_pass);
                  f = 32'(d2_fail); xa = d2_ea; xb = d2_eb; xo = d2_eo; xe = d2_ee; xg = d2_eg; end
      endcase
      check($sformatf("d%0d_busy", d), 32'(bz), (ph[d] == P_RUN || ph[d] == P_DRAIN) ? 1 : 0);
      check($sformatf("d%0d_done", d), 32'(dn), (ph[d] == P_DONE) ? 1 : 0);
      check($sformatf("d%0d_pass", d), p, mp[d]);
      check($sformatf("d%0d_fail", d), f, mf[d]);
      check($sformatf("d%0d_err", d), 32'(er), 32'(me[d]));
      check($sformatf("d%0d_err_a", d), xa, mea[d]);
      check($sformatf("d%0d_err_b", d), xb, meb[d]);
      check($sformatf("d%0d_err_op", d), xo, meo[d]);
      check($sformatf("d%0d_err_exp", d), xe, mee[d]);
      check($sformatf("d%0d_err_got", d), xg, meg[d]);
   endtask

   // One clock: drive at the falling edge, update the model at the rising edge, check at the next fall.
   task automatic tick(input bit v, input int unsigned ia, input int unsigned ib,
                       input int unsigned iop, input bit st, input bit sp, input bit r,
                       input bit fe, input int unsigned fv);
      int unsigned slot, k;
      int unsigned drv[3];
      slot = cyc % 8;
      ha[slot] = ia & 255; hb[slot] = ib & 255; hop[slot] = iop & 3;
      hv[slot] = v; hf[slot] = fe; hfv[slot] = fv & 255;
      for (int d = 0; d < 3; d++) begin
         k = (cyc + 8 - lat[d]) % 8;
         if (hv[k]) drv[d] = hf[k] ? hfv[k] : alu_ref(ha[k], hb[k], hop[k]);
         else       drv[d] = $urandom_range(0, 255);
      end
      valid = v; a = ha[slot][7:0]; b = hb[slot][7:0]; op = hop[slot][1:0];
      start = st; stop = sp; rst = r;
      r0 = drv[0][7:0]; r1 = drv[1][7:0]; r2 = drv[2][7:0];
      @(posedge clk);
      for (int d = 0; d < 3; d++) model_edge(d, v, st, sp, r, drv[d]);
      cyc++;
      @(negedge clk);
      for (int d = 0; d < 3; d++) check_dut(d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic issue(input int unsigned ia, input int unsigned ib, input int unsigned iop,
                        input bit st, input bit sp);
      tick(1, ia, ib, iop, st, sp, 0, 0, 0);
   endtask

   initial begin
      int unsigned busy_cycles, rr, fa, fb, fo;
      for (int d = 0; d < 3; d++) begin model_clear(d); ph[d] = P_IDLE; end
      for (int s = 0; s < 8; s++) begin hv[s] = 0; hf[s] = 0; ha[s] = 0; hb[s] = 0; hop[s] = 0; hfv[s] = 0; end
      rst = 1; start = 0; stop = 0; valid = 0; a = 0; b = 0; op = 0; r0 = 0; r1 = 0; r2 = 0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("rst_busy", 32'(d0_busy), 0);
      check("rst_pass", 32'(d1_pass), 0);

      // Basic ops back-to-back, then stop and drain.
      tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int o = 0; o < 4; o++) issue(8'h05, 8'h03, o, 0, 0);
      idle(2);
      tick(0, 0, 0, 0, 0, 1, 0, 0, 0);
      idle(4);
      check("t1_pass", 32'(d0_pass), 4);
      check("t1_fail", 32'(d0_fail), 0);
      check("t1_err", 32'(d0_err), 0);
      check("t1_done", 32'(d0_done), 1);
      check("t1_sat_pass", 32'(d2_pass), 3);

      // Wrap-around cases.
      tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
      issue(8'hFF, 8'h01, 0, 0, 0);
      issue(8'h00, 8'h01, 1, 0, 0);
      idle(4);
      check("wrap_pass", 32'(d0_pass), 2);
      check("wrap_fail", 32'(d0_fail), 0);

      // Two faults; the first one is retained.
      tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
      tick(1, 8'h0F, 8'hF0, 3, 0, 0, 0, 1, 8'h00);
      issue(8'h12, 8'h34, 0, 0, 0);
      issue(8'h80, 8'h81, 1, 0, 0);
      tick(1, 8'h33, 8'h0C, 2, 0, 0, 0, 1, 8'h55);
      idle(4);
      check("flt_fail", 32'(d0_fail), 2);
      check("flt_pass", 32'(d0_pass), 2);
      check("flt_err", 32'(d0_err), 1);
      check("flt_err_a", 32'(d0_ea), 8'h0F);
      check("flt_err_b", 32'(d0_eb), 8'hF0);
      check("flt_err_op", 32'(d0_eo), 3);
      check("flt_err_exp", 32'(d0_ee), 8'hFF);
      check("flt_err_got", 32'(d0_eg), 8'h00);
      check("flt_l3_fail", 32'(d1_fail), 2);
      check("flt_l3_err_a", 32'(d1_ea), 8'h0F);

      // LATENCY=3: stop with the fifth op, drain lasts three cycles.
      tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) issue($urandom_range(0, 255), $urandom_range(0, 255), i, 0, 0);
      busy_cycles = 0;
      issue(8'hA5, 8'h5A, 1, 0, 1);
      if (d1_busy) busy_cycles++;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         if (d1_busy) busy_cycles++;
      end
      check("l3_drain_cycles", busy_cycles, 3);
      check("l3_pass", 32'(d1_pass), 5);
      check("l3_done", 32'(d1_done), 1);

      // Restart with ops in flight: they are discarded.
      tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
      issue(8'h01, 8'h02, 0, 0, 0);
      issue(8'h03, 8'h04, 0, 0, 0);
      tick(1, 8'h07, 8'h07, 2, 1, 0, 0, 0, 0);
      check("rs_pass0", 32'(d0_pass), 0);
      idle(4);
      check("rs_pass3", 32'(d1_pass), 0);
      check("rs_fail3", 32'(d1_fail), 0);
      check("rs_busy3", 32'(d1_busy), 1);

      // Reset in the middle of a drain.
      for (int i = 0; i < 3; i++) issue($urandom_range(0, 255), $urandom_range(0, 255), i, 0, 0);
      issue(8'h11, 8'h22, 3, 0, 1);
      idle(1);
      tick(0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("mr_busy3", 32'(d1_busy), 0);
      check("mr_done3", 32'(d1_done), 0);
      check("mr_pass3", 32'(d1_pass), 0);
      for (int i = 0; i < 3; i++) issue($urandom_range(0, 255), $urandom_range(0, 255), i, 0, 0);
      check("idle_pass0", 32'(d0_pass), 0);

      // Randomized traffic with occasional faults, restarts, stops and resets.
      tick(0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         rr = $urandom_range(0, 99);
         fa = $urandom_range(0, 255);
         fb = $urandom_range(0, 255);
         fo = $urandom_range(0, 3);
         tick($urandom_range(0, 9) < 7, fa, fb, fo, rr < 4, rr >= 2 && rr < 9, rr == 99,
              $urandom_range(0, 9) == 0, $urandom_range(0, 255));
      end
      idle(6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
